// File: rtl/pid_pkg.sv
// pid_pkg: FSM state encoding and the signed saturation helper shared by the PID datapath.
package pid_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_ERROR, ST_PROD, ST_SUM, ST_CLAMP, ST_DONE} state_e;
  // Clamp v to the signed range of a w-bit value (w <= 63); caller truncates the result to w bits.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/pid_saturate.sv
// pid_saturate: limits a wide signed value to hi, then to lo (lo wins when lo > hi).
module pid_saturate #(
  parameter int IN_W  = 36,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  val,
  input  logic signed [OUT_W-1:0] lo,
  input  logic signed [OUT_W-1:0] hi,
  output logic signed [OUT_W-1:0] y
);
  logic signed [IN_W-1:0] lo_x, hi_x, t;
  always_comb begin
    lo_x = IN_W'(lo);
    hi_x = IN_W'(hi);
    t    = val > hi_x ? hi_x : val;
    y    = OUT_W'(t < lo_x ? lo_x : t);
  end
endmodule

// File: rtl/pid_multichannel.sv
// pid_multichannel: time-shared multi-channel PI controller, one sample per 6 cycles.
// Define PID_DERIV_EN to add the kd input and second-difference derivative term.
module pid_multichannel
  import pid_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int GAIN_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int CHANNELS = 4,
  localparam int CH_W    = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic [CH_W-1:0]          sample_ch,
  input  logic signed [DATA_W-1:0] setpoint,
  input  logic signed [DATA_W-1:0] measurement,
  input  logic signed [GAIN_W-1:0] kp,
  input  logic signed [GAIN_W-1:0] ki,
`ifdef PID_DERIV_EN
  input  logic signed [GAIN_W-1:0] kd,
`endif
  input  logic signed [DATA_W-1:0] u_min,
  input  logic signed [DATA_W-1:0] u_max,
  input  logic                     ch_clear,
  input  logic [CH_W-1:0]          ch_clear_idx,
  output logic signed [DATA_W-1:0] u_out,
  output logic [CH_W-1:0]          u_ch,
  output logic                     u_valid
);
  localparam int S_W = GAIN_W + DATA_W + 3;
  state_e state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d, u_ch_q, u_ch_d;
  logic signed [DATA_W-1:0] sp_q, sp_d, meas_q, meas_d, umin_q, umin_d, umax_q, umax_d;
  logic signed [DATA_W-1:0] e_q, e_d, u_out_q, u_out_d;
  logic signed [GAIN_W-1:0] kp_q, kp_d, ki_q, ki_d;
  logic signed [S_W-1:0] p_q, p_d, i_q, i_d, du_q, du_d, sum;
  logic u_valid_q, u_valid_d;
  logic signed [DATA_W-1:0] e_prev_q [CHANNELS];
  logic signed [DATA_W-1:0] e_prev_d [CHANNELS];
  logic signed [DATA_W-1:0] u_prev_q [CHANNELS];
  logic signed [DATA_W-1:0] u_prev_d [CHANNELS];
  logic signed [DATA_W:0] diff, de;
  logic signed [DATA_W-1:0] e_prev_cur, u_prev_cur, u_sat;
  logic signed [S_W:0] u_full;
  logic ch_ok, clr_ok, accept;
`ifdef PID_DERIV_EN
  logic signed [GAIN_W-1:0] kd_q, kd_d;
  logic signed [S_W-1:0] d_q, d_d;
  logic signed [DATA_W-1:0] e_prev2_q [CHANNELS];
  logic signed [DATA_W-1:0] e_prev2_d [CHANNELS];
  logic signed [DATA_W+1:0] dd;
  logic signed [DATA_W-1:0] e_prev2_cur;
  assign e_prev2_cur = ch_ok ? e_prev2_q[ch_q] : '0;
  assign sum = p_q + i_q + d_q;
`else
  assign sum = p_q + i_q;
`endif
  assign sample_ready = state_q == ST_IDLE && reset_b;
  assign accept       = sample_valid && sample_ready;
  assign ch_ok        = 32'(ch_q) < CHANNELS;
  assign clr_ok       = ch_clear && 32'(ch_clear_idx) < CHANNELS;
  assign e_prev_cur   = ch_ok ? e_prev_q[ch_q] : '0;
  assign u_prev_cur   = ch_ok ? u_prev_q[ch_q] : '0;
  assign u_full       = (S_W+1)'(u_prev_cur) + (S_W+1)'(du_q);
  assign u_out        = u_out_q;
  assign u_ch         = u_ch_q;
  assign u_valid      = u_valid_q;
  pid_saturate #(.IN_W(S_W + 1), .OUT_W(DATA_W)) u_clamp (
    .val(u_full), .lo(umin_q), .hi(umax_q), .y(u_sat)
  );
  always_comb begin
    state_d   = state_q == ST_IDLE ? (accept ? ST_ERROR : ST_IDLE) :
                state_q == ST_DONE ? ST_IDLE : state_e'(state_q + 3'd1);
    ch_d      = accept ? sample_ch : ch_q;
    sp_d      = accept ? setpoint : sp_q;
    meas_d    = accept ? measurement : meas_q;
    kp_d      = accept ? kp : kp_q;
    ki_d      = accept ? ki : ki_q;
    umin_d    = accept ? u_min : umin_q;
    umax_d    = accept ? u_max : umax_q;
    diff      = (DATA_W+1)'(sp_q) - (DATA_W+1)'(meas_q);
    de        = (DATA_W+1)'(e_q) - (DATA_W+1)'(e_prev_cur);
    e_d       = state_q == ST_ERROR ? DATA_W'(sat(64'(diff), DATA_W)) : e_q;
    p_d       = state_q == ST_PROD ? S_W'(kp_q) * S_W'(de) : p_q;
    i_d       = state_q == ST_PROD ? S_W'(ki_q) * S_W'(e_q) : i_q;
    du_d      = state_q == ST_SUM ? sum >>> FRAC_W : du_q;
    u_valid_d = state_q == ST_CLAMP && ch_ok;
    u_out_d   = u_valid_d ? u_sat : u_out_q;
    u_ch_d    = u_valid_d ? ch_q : u_ch_q;
    e_prev_d  = e_prev_q;
    u_prev_d  = u_prev_q;
`ifdef PID_DERIV_EN
    kd_d      = accept ? kd : kd_q;
    dd        = (DATA_W+2)'(e_q) - ((DATA_W+2)'(e_prev_cur) <<< 1) + (DATA_W+2)'(e_prev2_cur);
    d_d       = state_q == ST_PROD ? S_W'(kd_q) * S_W'(dd) : d_q;
    e_prev2_d = e_prev2_q;
    if (state_q == ST_DONE && ch_ok) e_prev2_d[ch_q] = e_prev_cur;
    if (clr_ok) e_prev2_d[ch_clear_idx] = '0;
`endif
    // u_out_q already holds the clamped value, so history never winds up past the limits
    if (state_q == ST_DONE && ch_ok) begin
      e_prev_d[ch_q] = e_q;
      u_prev_d[ch_q] = u_out_q;
    end
    if (clr_ok) begin
      e_prev_d[ch_clear_idx] = '0;
      u_prev_d[ch_clear_idx] = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      sp_q      <= '0;
      meas_q    <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      umin_q    <= '0;
      umax_q    <= '0;
      e_q       <= '0;
      p_q       <= '0;
      i_q       <= '0;
      du_q      <= '0;
      u_out_q   <= '0;
      u_ch_q    <= '0;
      u_valid_q <= 1'b0;
      e_prev_q  <= '{default: '0};
      u_prev_q  <= '{default: '0};
`ifdef PID_DERIV_EN
      kd_q      <= '0;
      d_q       <= '0;
      e_prev2_q <= '{default: '0};
`endif
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      sp_q      <= sp_d;
      meas_q    <= meas_d;
      kp_q      <= kp_d;
      ki_q      <= ki_d;
      umin_q    <= umin_d;
      umax_q    <= umax_d;
      e_q       <= e_d;
      p_q       <= p_d;
      i_q       <= i_d;
      du_q      <= du_d;
      u_out_q   <= u_out_d;
      u_ch_q    <= u_ch_d;
      u_valid_q <= u_valid_d;
      e_prev_q  <= e_prev_d;
      u_prev_q  <= u_prev_d;
`ifdef PID_DERIV_EN
      kd_q      <= kd_d;
      d_q       <= d_d;
      e_prev2_q <= e_prev2_d;
`endif
    end
  end
endmodule

// File: tb/tb_pid_multichannel.sv
// tb_pid_multichannel: directed table of samples with hand-computed outputs plus clear/reset corner cases.
module tb_pid_multichannel;
  logic clk = 1'b0;
  logic reset_b = 1'b0;
  logic sample_valid = 1'b0;
  logic sample_ready;
  logic [1:0] sample_ch = '0;
  logic signed [15:0] setpoint = '0, measurement = '0;
  logic signed [15:0] kp = '0, ki = '0;
`ifdef PID_DERIV_EN
  logic signed [15:0] kd = '0;
`endif
  logic signed [15:0] u_min = '0, u_max = '0;
  logic ch_clear = 1'b0;
  logic [1:0] ch_clear_idx = '0;
  logic signed [15:0] u_out;
  logic [1:0] u_ch;
  logic u_valid;

  int errors = 0;
  int checks = 0;
  int last_u = 0;

  typedef struct {
    int ch, sp, meas, kp, ki, kd, umin, umax;
    bit vld;
    int u;
  } vec_t;
  vec_t vecs[12];

  pid_multichannel #(.DATA_W(16), .GAIN_W(16), .FRAC_W(8), .CHANNELS(3)) dut (
    .clk(clk), .reset_b(reset_b), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_ch(sample_ch), .setpoint(setpoint), .measurement(measurement), .kp(kp), .ki(ki),
`ifdef PID_DERIV_EN
    .kd(kd),
`endif
    .u_min(u_min), .u_max(u_max), .ch_clear(ch_clear), .ch_clear_idx(ch_clear_idx),
    .u_out(u_out), .u_ch(u_ch), .u_valid(u_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sample_ch   = 2'(v.ch);
    setpoint    = 16'(v.sp);
    measurement = 16'(v.meas);
    kp          = 16'(v.kp);
    ki          = 16'(v.ki);
`ifdef PID_DERIV_EN
    kd          = 16'(v.kd);
`endif
    u_min       = 16'(v.umin);
    u_max       = 16'(v.umax);
  endtask

  // One sample end to end; optionally pulses ch_clear for channel 0 in the DONE cycle.
  task automatic send(input vec_t v, input bit clr_done, input string name);
    int n = 0;
    int seen = 0;
    @(negedge clk);
    while (!sample_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " ready"}, longint'(sample_ready), 1);
    drive(v);
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) chk({name, " busy"}, longint'(sample_ready), 0);
      if (u_valid && seen == 0) seen = k;
      if (k == 5) begin
        chk({name, " u_out"}, longint'(u_out), v.vld ? v.u : last_u);
        if (v.vld) chk({name, " u_ch"}, longint'(u_ch), v.ch);
        if (clr_done) begin
          ch_clear = 1'b1;
          ch_clear_idx = 2'd0;
        end
      end
      if (k == 6) begin
        ch_clear = 1'b0;
        if (v.vld) chk({name, " hold"}, longint'(u_out), v.u);
      end
    end
    chk({name, " latency"}, seen, v.vld ? 5 : 0);
    if (v.vld) last_u = v.u;
  endtask

  initial begin
    int seen;
    vec_t h;
    //           ch  sp      meas    kp   ki   kd  umin    umax   vld  u
    vecs[0]  = '{0,  100,    0,      256, 256, 0, -1000,  1000,  1, 200};
    vecs[1]  = '{1,  50,     0,      256, 0,   0, -1000,  1000,  1, 50};
    vecs[2]  = '{0,  100,    0,      256, 256, 0, -1000,  1000,  1, 300};
    vecs[3]  = '{3,  100,    0,      256, 256, 0, -1000,  1000,  0, 0};
    vecs[4]  = '{0,  100,    0,      256, 256, 0, -1000,  250,   1, 250};
    vecs[5]  = '{0,  100,    0,      256, 256, 0, -1000,  250,   1, 250};
    vecs[6]  = '{0,  0,      0,      256, 256, 0, -1000,  250,   1, 150};
    vecs[7]  = '{2,  32767,  -32768, 256, 0,   0, -32768, 32767, 1, 32767};
    vecs[8]  = '{1,  0,      40,     0,   1,   0, -1000,  1000,  1, 49};
    vecs[9]  = '{1,  10,     0,      256, 0,   0, 500,    100,   1, 500};
    vecs[10] = '{2,  -32768, 32767,  0,   256, 0, -32768, 32767, 1, -1};
    vecs[11] = '{0,  0,      -20,    256, 256, 0, -1000,  1000,  1, 190};

    repeat (3) @(negedge clk);
    chk("reset ready", longint'(sample_ready), 0);
    chk("reset u_out", longint'(u_out), 0);
    chk("reset u_valid", longint'(u_valid), 0);
    chk("reset u_ch", longint'(u_ch), 0);
    reset_b = 1'b1;
    #1 chk("release ready", longint'(sample_ready), 1);

    for (int i = 0; i < 12; i++) send(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Saturated error with channel-0 clear landing in the DONE cycle; clear must win.
    h = '{0, 32767, -32768, 256, 0, 0, -1000, 1000, 1, 1000};
    send(h, 1'b1, "clear_done");
    h = '{0, 100, 0, 256, 256, 0, -1000, 1000, 1, 200};
    send(h, 1'b0, "after_clear");

    // Reset asserted while the sample sits in PROD.
    seen = 0;
    @(negedge clk);
    h = '{0, 100, 0, 256, 256, 0, -1000, 1000, 1, 200};
    drive(h);
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    @(negedge clk);
    if (u_valid) seen = 1;
    @(negedge clk);
    if (u_valid) seen = 1;
    reset_b = 1'b0;
    @(negedge clk);
    if (u_valid) seen = 1;
    chk("midreset u_out", longint'(u_out), 0);
    chk("midreset ready", longint'(sample_ready), 0);
    reset_b = 1'b1;
    #1 chk("midreset release ready", longint'(sample_ready), 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (u_valid) seen = 1;
    end
    chk("midreset no u_valid", seen, 0);
    last_u = 0;
    h = '{1, 100, 0, 256, 256, 0, -1000, 1000, 1, 200};
    send(h, 1'b0, "post_reset ch1");

`ifdef PID_DERIV_EN
    h = '{2, 10, 0, 0, 0, 256, -1000, 1000, 1, 10};
    send(h, 1'b0, "deriv e10");
    h = '{2, 20, 0, 0, 0, 256, -1000, 1000, 1, 10};
    send(h, 1'b0, "deriv e20");
    h = '{2, 20, 0, 0, 0, 256, -1000, 1000, 1, 0};
    send(h, 1'b0, "deriv e20b");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
